// File: rtl/eq_quant_apply.sv
// Equaliser gain apply and 4-bit requantiser: complex Fix_18_17 samples are scaled
// by a spectrum-latched UFix_16_8 gain, rounded, saturated to Fix_4_3 and packed.
module eq_quant_lane (
    input  logic        i_clk,
    input  logic [17:0] i_din,
    input  logic [15:0] i_gain,
    output logic [3:0]  o_q,
    output logic        o_sat
);
    logic        [17:0] r_din;
    logic signed [34:0] r_prod;
    logic signed [34:0] w_rnd;
    logic signed [34:0] w_sh;

    // Data path carries no reset; qualification comes from the valid pipe in the top.
    always_ff @(posedge i_clk) begin
        r_din  <= i_din;
        r_prod <= $signed(r_din) * $signed({1'b0, i_gain});
    end

    // Fix_35_25 -> Fix_4_3: add half an output LSB, then drop 22 fraction bits.
    assign w_rnd = r_prod + 35'sd2097152;
    assign w_sh  = w_rnd >>> 22;

    always_comb begin
        o_sat = 1'b0;
        o_q   = w_sh[3:0];
        if (w_sh > 35'sd7) begin
            o_sat = 1'b1;
            o_q   = 4'h7;
        end else if (w_sh < -35'sd7) begin
            o_sat = 1'b1;
            o_q   = 4'h9;
        end
    end
endmodule

module eq_quant_apply #(
    parameter int CNT_W = 16
) (
    input  logic             user_clk,
    input  logic             user_rst_n,
    input  logic [31:0]      gain_reg,
    input  logic             sync_in,
    input  logic             din_valid,
    input  logic [17:0]      din_re,
    input  logic [17:0]      din_im,
    input  logic             ovf_clr,
    output logic [7:0]       dout,
    output logic             dout_valid,
    output logic             sync_out,
    output logic [CNT_W-1:0] ovf_cnt
);
    localparam int NUM_LANES = 2;
    localparam int STAGES    = 3;

    logic                            r_rst_meta;
    logic                            r_rst_sync;
    logic                            w_rst_n;
    logic [15:0]                     r_active_gain;
    logic [15:0]                     r_s1_gain;
    logic [STAGES-1:0]               r_vld_pipe;
    logic [STAGES-1:0]               r_sync_pipe;
    logic [7:0]                      r_dout;
    logic [CNT_W-1:0]                r_ovf_cnt;
    logic [NUM_LANES-1:0][17:0]      w_din;
    logic [NUM_LANES-1:0][3:0]       w_q;
    logic [NUM_LANES-1:0]            w_sat;
    logic                            w_ovf_hit;
    logic                            w_unused;

    assign w_unused = ^gain_reg[31:16];

    // Reset asserts immediately but releases two edges after user_rst_n rises.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end
    assign w_rst_n = r_rst_sync;

    // S1 captures the gain held before any reload, so the sync cycle uses the old gain.
    always_ff @(posedge user_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_active_gain <= '0;
            r_s1_gain     <= '0;
            r_vld_pipe    <= '0;
            r_sync_pipe   <= '0;
        end else begin
            if (sync_in)
                r_active_gain <= gain_reg[15:0];
            r_s1_gain   <= r_active_gain;
            r_vld_pipe  <= {r_vld_pipe[STAGES-2:0], din_valid};
            r_sync_pipe <= {r_sync_pipe[STAGES-2:0], sync_in};
        end
    end

    assign w_din = {din_re, din_im};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        eq_quant_lane u_lane (
            .i_clk  (user_clk),
            .i_din  (w_din[g]),
            .i_gain (r_s1_gain),
            .o_q    (w_q[g]),
            .o_sat  (w_sat[g])
        );
    end

    assign w_ovf_hit = r_vld_pipe[STAGES-2] & (|w_sat);

    // A clear coinciding with a saturating sample leaves that sample counted.
    always_ff @(posedge user_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_dout    <= '0;
            r_ovf_cnt <= '0;
        end else begin
            r_dout <= r_vld_pipe[STAGES-2] ? w_q : 8'h00;
            if (ovf_clr)
                r_ovf_cnt <= CNT_W'(w_ovf_hit);
            else if (w_ovf_hit && (r_ovf_cnt != {CNT_W{1'b1}}))
                r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_vld_pipe[STAGES-1];
    assign sync_out   = r_sync_pipe[STAGES-1];
    assign ovf_cnt    = r_ovf_cnt;
endmodule

// File: doc/eq_quant_apply.md
EQ_QUANT_APPLY -- requirements
Module: eq_quant_apply

Interface
REQ-001 Parameter CNT_W, default 16: width of the overflow counter.
REQ-002 user_clk  input  1  sole clock; all state is updated on its rising edge.
REQ-003 user_rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 gain_reg  input  32  software equaliser gain from the EQ quant0 gain register (user_clk domain); only bits [15:0] are used, UFix_16_8, so 0x0100 = 1.0.
REQ-005 sync_in  input  1  one-cycle pulse one cycle before the first channel of a spectrum.
REQ-006 din_valid  input  1  qualifies din_re/din_im.
REQ-007 din_re, din_im  input  18 each  channel sample, signed Fix_18_17.
REQ-008 ovf_clr  input  1  synchronous clear of ovf_cnt.
REQ-009 dout  output  8  {re4, im4}; each nibble is signed Fix_4_3.
REQ-010 dout_valid  output  1  qualifies dout.
REQ-011 sync_out  output  1  sync_in delayed to align with dout.
REQ-012 ovf_cnt  output  CNT_W  count of saturated output samples.

Function
REQ-013 The block SHALL hold active_gain[15:0], loaded from gain_reg[15:0] only at an edge where sync_in=1.
REQ-014 A sample presented at cycle t SHALL use the active_gain value held at t; a sample presented on the sync_in cycle uses the previous gain.
REQ-015 Changes on gain_reg without sync_in SHALL have no effect on the output.
REQ-016 The pipeline SHALL be 3 stages: S1 registers inputs and gain; S2 forms signed 18 x zero-extended 17-bit products (Fix_35_25); S3 rounds, saturates and packs.
REQ-017 Input-to-output latency SHALL be exactly 3 cycles for dout, dout_valid and sync_out.
REQ-018 din_valid SHALL be carried alongside the data; there is no backpressure and every valid input produces a valid output.
REQ-019 Rounding SHALL add 2^21 to the product, then shift right arithmetically by 22 bits (round half up toward +inf).
REQ-020 Saturation SHALL clamp the rounded value to [-7,+7]; -8 and below map to -7 (0x9), +8 and above map to +7 (0x7).
REQ-021 dout SHALL be 8'h00 whenever dout_valid=0.
REQ-022 A valid output sample with saturation on re, im or both SHALL increment ovf_cnt by exactly 1.
REQ-023 ovf_cnt SHALL stick at all-ones and not wrap.
REQ-024 When ovf_clr and a saturating sample occur in the same cycle, ovf_cnt SHALL be 1.
REQ-025 sync_out SHALL be propagated independently of din_valid.
REQ-026 Back-to-back sync_in pulses SHALL each reload active_gain and each appear on sync_out.
REQ-027 active_gain SHALL reset to 0, so all outputs are 0 until the first sync_in.

Reset
REQ-028 While user_rst_n=0, dout=0, dout_valid=0, sync_out=0, ovf_cnt=0, active_gain=0, and all pipeline valid and sync bits are 0, asynchronously.
REQ-029 Reset deassertion SHALL be synchronised internally; the first valid output may appear 3 cycles after the first post-reset valid input.
REQ-030 Asserting reset mid-stream SHALL discard in-flight samples; no valid or sync pulse emerges from them after release.

Verification
REQ-031 Reset, gain_reg=0x0100, no sync_in, din_re=18'h10000 valid -> dout=0x00 with dout_valid=1 (active_gain=0).
REQ-032 sync_in, then gain 0x0100; din_re=18'h10000 (0.5), din_im=18'h38000 (-0.25) -> 3 cycles later dout=0x4E; sync_out 3 cycles after sync_in; ovf_cnt=0.
REQ-033 Gain 0x0400 (4.0), din_re=18'h10000, din_im=18'h30000 (-0.5) -> dout=0x79; ovf_cnt increments by 1 per sample; ovf_clr together with a saturating sample -> ovf_cnt=1.
REQ-034 Rounding, gain 0x0100: din_re=18'h02000 (+0.5 LSB), din_im=18'h3E000 (-0.5 LSB) -> dout=0x10; ovf_cnt unchanged.
REQ-035 gain_reg changed to 0 mid-spectrum -> output unchanged until the next sync_in; samples after that sync -> dout=0x00.
REQ-036 Pull user_rst_n low with 3 valid samples in flight -> all outputs 0 immediately; after release, no stale dout_valid or sync_out.
